// File: rtl/cpu_io_pkg.sv
// Shared types for the CPU board I/O blocks: switch-capture FSM states and B-bus width.
package cpu_io_pkg;

    localparam int SW_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        CAPTURE,
        HELD,
        RELEASE_DB
    } swcap_state_t;

endpackage

// File: rtl/switch_capture_if.sv
// Board-side signals of the switch capture stage: raw switches/button in, held word out.
interface switch_capture_if
    import cpu_io_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);
    // Handshake: sw_valid stays high while inSwitch holds an unconsumed word; the
    // controller consumes it with a one-cycle sw_ack, and sw_valid falls on the edge
    // that samples that ack. An ack seen while sw_valid is low is ignored.
    logic [WIDTH-1:0] raw_switch;
    logic             raw_load_btn;
    logic             sw_ack;
    logic [WIDTH-1:0] inSwitch;
    logic             sw_valid;
    logic             sw_overrun;

    modport master (
        output raw_switch,
        output raw_load_btn,
        output sw_ack,
        input  inSwitch,
        input  sw_valid,
        input  sw_overrun
    );

    modport slave (
        input  raw_switch,
        input  raw_load_btn,
        input  sw_ack,
        output inSwitch,
        output sw_valid,
        output sw_overrun
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; synchronous active-low reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/switch_capture.sv
// Synchronises the slide switches and load button, debounces the button and captures
// one switch word per clean press into a held register with valid/overrun flags.
module switch_capture
    import cpu_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic           in_clk,
    input  logic           in_reset_n,
    switch_capture_if.slave sw_if,
    output swcap_state_t   dbg_state_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_sync;
    logic             btn_sync;

    swcap_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;

    sync_2ff #(.WIDTH(WIDTH)) u_sync_sw (
        .clk_i  (in_clk),
        .rst_ni (in_reset_n),
        .d_i    (sw_if.raw_switch),
        .q_o    (sw_sync)
    );

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk_i  (in_clk),
        .rst_ni (in_reset_n),
        .d_i    (sw_if.raw_load_btn),
        .q_o    (btn_sync)
    );

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // In the capture cycle the capture itself decides the flags; see CAPTURE.
            if (state_q != CAPTURE && sw_if.sw_ack && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        cnt_q   <= '0;
                        state_q <= PRESS_DB;
                    end
                end

                PRESS_DB: begin
                    if (!btn_sync) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                CAPTURE: begin
                    data_q  <= sw_sync;
                    valid_q <= 1'b1;
                    // A coincident ack consumed the old word, so it is not an overrun.
                    if (valid_q && !sw_if.sw_ack) begin
                        overrun_q <= 1'b1;
                    end else if (valid_q && sw_if.sw_ack) begin
                        overrun_q <= 1'b0;
                    end
                    state_q <= HELD;
                end

                HELD: begin
                    if (!btn_sync) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE_DB;
                    end
                end

                RELEASE_DB: begin
                    if (btn_sync) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign sw_if.inSwitch   = data_q;
    assign sw_if.sw_valid   = valid_q;
    assign sw_if.sw_overrun = overrun_q;
    assign dbg_state_o      = state_q;

endmodule

// File: doc/switch_capture.md
# switch_capture

Input-port stage that feeds the `inSwitch` operand of the B-bus multiplexer. It synchronises the 8 board slide switches and a raw "load" push-button into `in_clk`, debounces the button, and captures one switch word per clean press into a held register. It raises a valid flag that the controller acknowledges when an IN-type instruction consumes the word.

## Interface
- `WIDTH`, default 8: switch / data width; must match the B-bus width.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required for press and for release; legal range ≥ 2.
- `in_clk`  in  1  system clock; all state changes on its rising edge.
- `in_reset_n`  in  1  reset, synchronous, active-low.
- `raw_switch`  in  WIDTH  asynchronous slide-switch levels.
- `raw_load_btn`  in  1  asynchronous push-button, active-high, bouncy.
- `sw_ack`  in  1  controller has consumed the current word; one-cycle pulse.
- `inSwitch`  out  WIDTH  captured switch word, registered, held until the next capture; drives the mux `inSwitch` input.
- `sw_valid`  out  1  an unconsumed word is present in `inSwitch`.
- `sw_overrun`  out  1  sticky; a new capture overwrote an unconsumed word.

## Operation
- Both raw inputs pass through a 2-flop synchroniser, giving `sw_sync` and `btn_sync`. Synchroniser flops reset to 0.
- The debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide and saturates at `DEBOUNCE_CYCLES-1`.
- FSM states: IDLE, PRESS_DB, CAPTURE, HELD, RELEASE_DB.
  - **IDLE:** when `btn_sync`=1, set `cnt`←0 and go to PRESS_DB.
  - **PRESS_DB:** when `btn_sync`=0, go to IDLE; this rejects the glitch and captures nothing. Otherwise, when `cnt`=`DEBOUNCE_CYCLES-1`, go to CAPTURE; otherwise increment `cnt`.
  - **CAPTURE** (exactly one cycle): set `inSwitch`←`sw_sync` and `sw_valid`←1. If `sw_valid` was 1 and `sw_ack`=0 this cycle, set `sw_overrun`←1. Then go to HELD.
  - **HELD:** when `btn_sync`=0, set `cnt`←0 and go to RELEASE_DB. A held button never captures twice.
  - **RELEASE_DB:** when `btn_sync`=1, go to HELD. Otherwise, when `cnt`=`DEBOUNCE_CYCLES-1`, go to IDLE; otherwise increment `cnt`.
- Acknowledge handling:
  - `sw_ack`=1 while `sw_valid`=1 clears `sw_valid` and `sw_overrun` on the next edge.
  - `sw_ack` while `sw_valid`=0 is ignored.
  - `inSwitch` is never cleared by ack.
- Simultaneous CAPTURE and `sw_ack`: the capture wins. `sw_valid` stays 1, `inSwitch` takes the new word, and `sw_overrun` is cleared, because the old word counts as consumed.
- `raw_switch` changes during debounce are allowed. The captured word is `sw_sync` in the CAPTURE cycle.

## Timing
- Reset values (when `in_reset_n`=0 at an edge):
  - state IDLE, `cnt`=0, synchronisers 0;
  - `inSwitch`=0, `sw_valid`=0, `sw_overrun`=0.
- Reset mid-operation abandons any debounce. If the button is still held after reset release, it is treated as a new press.
- Press latency:
  - Let edge 0 be the first edge sampling `raw_load_btn`=1, with the button steady from then on.
  - `btn_sync`=1 after edge 1.
  - PRESS_DB is entered at edge 2.
  - CAPTURE is entered at edge `DEBOUNCE_CYCLES+2`.
  - `sw_valid`/`inSwitch` update at edge `DEBOUNCE_CYCLES+3`; this is edge 19 for the default.
- Release needs `DEBOUNCE_CYCLES+2` stable-low edges before IDLE is re-entered (from the first low sample).
- Ack latency: `sw_valid` falls on the edge that samples `sw_ack`=1.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package `cpu_io_pkg`:
  - `typedef enum logic [2:0] {IDLE, PRESS_DB, CAPTURE, HELD, RELEASE_DB} swcap_state_t`;
  - localparam `SW_WIDTH = 8`.
- One sub-module, `sync_2ff #(WIDTH)`: a 2-flop synchroniser with synchronous active-low reset to 0, instantiated for `raw_switch` (WIDTH) and for `raw_load_btn` (1).
- The FSM, counter and output registers live in `switch_capture`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Clean press:** `raw_switch`=8'hA5, button held high from edge 0 → `sw_valid` rises at edge 7 with `inSwitch`=8'hA5; no second capture while held.
- **Glitch:** button high for 3 edges then low → state returns to IDLE; `sw_valid`=0 and `inSwitch` unchanged.
- **Ack:** after the capture, pulse `sw_ack` for 1 cycle → `sw_valid`=0 next edge and `inSwitch` still 8'hA5; an ack with `sw_valid`=0 has no effect.
- **Overrun:** capture 8'h0F, release for ≥6 edges, press again with 8'hF0 and no ack → `inSwitch`=8'hF0, `sw_valid`=1, `sw_overrun`=1; a subsequent ack clears both flags.
- **Ack coincident with CAPTURE:** `sw_valid`=1, `sw_ack` in the CAPTURE cycle → `sw_valid`=1, new word loaded, `sw_overrun`=0.
- **Bouncy release then reset mid-debounce:**
  - Release bouncing 1-0-1-0 → returns to HELD each time; no capture.
  - Assert `in_reset_n`=0 during PRESS_DB → all outputs 0 on the next edge.
  - Button held through reset release → capture after `DEBOUNCE_CYCLES+3` edges.
